// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch program counter
//
// Contents:
//   fetch_state_t : sequencer state (IDLE / RUN / HALTED)
//   PC_W          : default program-counter width
//   BR_CNT_W      : width of the optional taken-branch counter
//   BR_CNT_MAX    : saturation value of that counter
package fetch_pkg;

   localparam int PC_W     = 12;
   localparam int BR_CNT_W = 16;

   localparam logic [BR_CNT_W-1:0] BR_CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      HALTED = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational advance of the program counter
//
// Ports:
//   pc           in  : current program counter
//   branch_en    in  : current instruction is a branch
//   branch_taken in  : branch condition holds
//   target       in  : signed relative offset for a taken branch
//   next_pc      out : pc + target on a taken branch, pc + 1 otherwise
//
// Hold conditions (halt, stall, idle) are decided by the caller; this block
// only answers "where would the PC go if it moves". Sums are D bits wide,
// so both the increment and negative offsets wrap modulo 2^D.
module pc_next_calc
   import fetch_pkg::*;
#(
   parameter int D = PC_W
) (
   input  logic [D-1:0] pc,
   input  logic         branch_en,
   input  logic         branch_taken,
   input  logic [D-1:0] target,
   output logic [D-1:0] next_pc
);

   localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

   always_comb begin
      next_pc = pc + ONE;
      if (branch_en && branch_taken) begin
         // Two's-complement add: a target with the top bit set moves backwards.
         next_pc = pc + target;
      end
   end

endmodule

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program-counter sequencer with start/stall/branch/halt
//
// Optional feature: define FETCH_PC_BRANCH_CNT_EN to add the br_count output.
//
// Ports:
//   clk          in  : clock, all state on rising edge
//   reset_n      in  : synchronous active-low reset
//   start        in  : begin fetching at START_ADDR (from IDLE or HALTED)
//   stall        in  : hold the PC this cycle
//   branch_en    in  : current instruction is a branch
//   branch_taken in  : branch condition holds
//   target       in  : signed relative branch offset
//   halt         in  : current instruction ends the program
//   prog_ctr     out : fetch address (registered)
//   valid        out : prog_ctr is live (state RUN)
//   done         out : program halted (state HALTED)
//   br_count     out : taken branches applied in RUN, saturating (optional)
module fetch_pc
   import fetch_pkg::*;
#(
   parameter int           D          = PC_W,
   parameter logic [D-1:0] START_ADDR = '0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         stall,
   input  logic         branch_en,
   input  logic         branch_taken,
   input  logic [D-1:0] target,
   input  logic         halt,
   output logic [D-1:0] prog_ctr,
   output logic         valid,
   output logic         done
`ifdef FETCH_PC_BRANCH_CNT_EN
   ,
   output logic [BR_CNT_W-1:0] br_count
`endif
);

   fetch_state_t state_q;
   fetch_state_t state_d;
   logic [D-1:0] pc_q;
   logic [D-1:0] pc_d;
   logic [D-1:0] adv_pc;

   pc_next_calc #(
      .D (D)
   ) u_next (
      .pc           (pc_q),
      .branch_en    (branch_en),
      .branch_taken (branch_taken),
      .target       (target),
      .next_pc      (adv_pc)
   );

   // State register: reset wins over every other input on the same edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state and next PC. In RUN, halt beats stall beats branch/increment.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: begin
            pc_d = '0;
            if (start) begin
               state_d = RUN;
               pc_d    = START_ADDR;
            end
         end
         RUN: begin
            if (halt) begin
               state_d = HALTED;
            end else if (!stall) begin
               pc_d = adv_pc;
            end
         end
         HALTED: begin
            if (start) begin
               state_d = RUN;
               pc_d    = START_ADDR;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
         end
      endcase
   end

   // Outputs depend on registered state only, so inputs never reach them
   // combinationally.
   always_comb begin
      valid = 1'b0;
      done  = 1'b0;
      case (state_q)
         RUN:     valid = 1'b1;
         HALTED:  done  = 1'b1;
         default: begin
            valid = 1'b0;
            done  = 1'b0;
         end
      endcase
   end

   assign prog_ctr = pc_q;

`ifdef FETCH_PC_BRANCH_CNT_EN
   logic br_inc;
   logic br_clr;

   // Count only branches that actually redirect the PC: halt and stall
   // both suppress the redirect, so they suppress the count too.
   assign br_inc = (state_q == RUN) && !halt && !stall && branch_en && branch_taken;
   assign br_clr = start && (state_q != RUN);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         br_count <= '0;
      end else if (br_clr) begin
         br_count <= '0;
      end else if (br_inc && (br_count != BR_CNT_MAX)) begin
         br_count <= br_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - scoreboard testbench for fetch_pc
module tb_fetch_pc;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        stall;
   logic        branch_en;
   logic        branch_taken;
   logic [11:0] target;
   logic        halt;
   logic [11:0] prog_ctr;
   logic        valid;
   logic        done;
`ifdef FETCH_PC_BRANCH_CNT_EN
   logic [15:0] br_count;
`endif

   typedef struct packed {
      logic [11:0] pc;
      logic        v;
      logic        d;
      logic [15:0] br;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    tests;
   int    fails;

   fetch_pc dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .stall        (stall),
      .branch_en    (branch_en),
      .branch_taken (branch_taken),
      .target       (target),
      .halt         (halt),
      .prog_ctr     (prog_ctr),
      .valid        (valid),
      .done         (done)
`ifdef FETCH_PC_BRANCH_CNT_EN
      ,
      .br_count     (br_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: the DUT presents a new result after every rising edge.
   always @(posedge clk) begin
      exp_t  e;
      string nm;
      #1;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         tests++;
         if (prog_ctr !== e.pc || valid !== e.v || done !== e.d) begin
            fails++;
            $display("FAIL %s: got pc=%h valid=%b done=%b, want pc=%h valid=%b done=%b",
                     nm, prog_ctr, valid, done, e.pc, e.v, e.d);
         end
`ifdef FETCH_PC_BRANCH_CNT_EN
         tests++;
         if (br_count !== e.br) begin
            fails++;
            $display("FAIL %s_br: got br_count=%0d, want %0d", nm, br_count, e.br);
         end
`endif
      end
   end

   // Drive one cycle of inputs and queue what must appear after the edge.
   task automatic step(input logic rn, input logic st, input logic sl,
                       input logic be, input logic bt, input logic [11:0] tg,
                       input logic hl, input logic [11:0] epc, input logic ev,
                       input logic ed, input logic [15:0] ebr, input string nm);
      exp_t e;
      @(negedge clk);
      reset_n      = rn;
      start        = st;
      stall        = sl;
      branch_en    = be;
      branch_taken = bt;
      target       = tg;
      halt         = hl;
      e.pc = epc;
      e.v  = ev;
      e.d  = ed;
      e.br = ebr;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   initial begin
      int budget;
      tests = 0;
      fails = 0;
      reset_n = 1'b0; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
      branch_taken = 1'b0; target = 12'h000; halt = 1'b0;

      //   rn  st  sl  be  bt  tgt     hl   pc      v  d  br
      step(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0, "reset");
      step(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0, "idle_hold");
      step(1, 0, 1, 1, 1, 12'h005, 1, 12'h000, 0, 0, 0, "idle_ignores");
      step(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, "start");
      step(1, 0, 0, 0, 0, 12'h000, 0, 12'h001, 1, 0, 0, "inc1");
      step(1, 0, 0, 0, 0, 12'h000, 0, 12'h002, 1, 0, 0, "inc2");
      step(1, 0, 0, 0, 0, 12'h000, 0, 12'h003, 1, 0, 0, "inc3");
      step(1, 0, 0, 1, 1, 12'h006, 0, 12'h009, 1, 0, 1, "branch_fwd");
      step(1, 0, 0, 1, 1, 12'hFF7, 0, 12'h000, 1, 0, 2, "branch_back");
      step(1, 1, 0, 0, 0, 12'h000, 0, 12'h001, 1, 0, 2, "start_in_run");
      step(1, 0, 0, 1, 0, 12'h006, 0, 12'h002, 1, 0, 2, "not_taken");
      step(1, 0, 0, 0, 1, 12'h006, 0, 12'h003, 1, 0, 2, "not_branch");
      step(1, 0, 0, 1, 1, 12'h000, 0, 12'h003, 1, 0, 3, "self_loop");
      step(1, 0, 0, 1, 1, 12'hFFC, 0, 12'hFFF, 1, 0, 4, "neg_wrap");
      step(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 4, "inc_wrap");
      step(1, 0, 0, 1, 1, 12'h005, 0, 12'h005, 1, 0, 5, "to5");
      step(1, 0, 1, 1, 1, 12'h007, 0, 12'h005, 1, 0, 5, "stall1");
      step(1, 0, 1, 0, 0, 12'h000, 0, 12'h005, 1, 0, 5, "stall2");
      step(1, 0, 1, 0, 0, 12'h000, 0, 12'h005, 1, 0, 5, "stall3");
      step(1, 0, 0, 0, 0, 12'h000, 0, 12'h006, 1, 0, 5, "unstall");
      step(1, 0, 0, 0, 0, 12'h000, 0, 12'h007, 1, 0, 5, "to7");
      step(1, 0, 0, 1, 1, 12'h003, 1, 12'h007, 0, 1, 5, "halt");
      step(1, 0, 0, 1, 1, 12'h003, 0, 12'h007, 0, 1, 5, "halted_hold");
      step(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, "restart");
      step(1, 0, 0, 1, 1, 12'h014, 0, 12'h014, 1, 0, 1, "to20");
      step(0, 1, 1, 1, 1, 12'h003, 1, 12'h000, 0, 0, 0, "reset_mid_run");
      step(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0, "post_reset_idle");
      step(1, 1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, "start2");
      step(1, 0, 1, 1, 1, 12'h004, 1, 12'h000, 0, 1, 0, "halt_over_stall");
      step(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0, "reset_halted");
      step(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0, "final_idle");

      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
